// File: rtl/subtracter_8bit_core.sv
// rtl/subtracter_8bit_core.sv - 8-bit ripple subtracter with registered diff/borrow; SUB_OVERFLOW_EN adds overflow
module subtracter_8bit_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff,
`ifdef SUB_OVERFLOW_EN
    output logic       overflow,
`endif
    output logic       borrow
);

    logic [7:0] diff_d;
    logic [7:0] diff_q;
    logic       borrow_d;
    logic       borrow_q;
    logic [8:0] bw;

    // bw[i] is the borrow into cell i; bw[8] is the borrow out of the top cell.
    always_comb begin
        bw     = 9'd0;
        diff_d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            diff_d[i] = a[i] ^ b[i] ^ bw[i];
            bw[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
        end
        borrow_d = ~bw[8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q   <= 8'd0;
            borrow_q <= 1'b0;
        end else begin
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SUB_OVERFLOW_EN
    logic overflow_d;
    logic overflow_q;

    assign overflow_d = (a[7] ^ b[7]) & (a[7] ^ diff_d[7]);

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_subtracter_8bit_core.sv
// tb/tb_subtracter_8bit_core.sv - scoreboard bench for subtracter_8bit_core
module tb_subtracter_8bit_core;

    typedef struct {
        int         tag;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
`ifdef SUB_OVERFLOW_EN
    logic       overflow;
`endif

    logic       stim_valid;
    logic       stim_done;
    exp_t       sb_q[$];
    int         checks;
    int         errors;

    subtracter_8bit_core dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .diff     (diff),
`ifdef SUB_OVERFLOW_EN
        .overflow (overflow),
`endif
        .borrow   (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's worth of stimulus and push what must appear after that edge.
    task automatic drive(input int tag, input logic r, input logic [7:0] ra, input logic [7:0] rb,
                         input logic [7:0] ed, input logic eb, input logic eo);
        exp_t e;
        @(negedge clk);
        rst        = r;
        a          = ra;
        b          = rb;
        stim_valid = 1'b1;
        e.tag    = tag;
        e.diff   = ed;
        e.borrow = eb;
        e.ovf    = eo;
        sb_q.push_back(e);
    endtask

    // Monitor: every edge that had stimulus produces one result to compare.
    initial begin
        logic vp;
        exp_t e;
        forever begin
            @(posedge clk);
            vp = stim_valid;
            #1;
            if (vp) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: result present with no expected entry");
                end else begin
                    e = sb_q.pop_front();
                    if (diff !== e.diff) begin
                        errors++;
                        $display("FAIL diff tag=%0d: got %02h expected %02h", e.tag, diff, e.diff);
                    end
                    checks++;
                    if (borrow !== e.borrow) begin
                        errors++;
                        $display("FAIL borrow tag=%0d: got %b expected %b", e.tag, borrow, e.borrow);
                    end
`ifdef SUB_OVERFLOW_EN
                    checks++;
                    if (overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL overflow tag=%0d: got %b expected %b", e.tag, overflow, e.ovf);
                    end
`endif
                end
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ed;
        int         wait_cycles;

        checks     = 0;
        errors     = 0;
        stim_done  = 1'b0;
        stim_valid = 1'b0;
        rst        = 1'b1;
        a          = 8'h00;
        b          = 8'h00;

        vecs[0]  = '{8'h0A, 8'h03, 8'h07, 1'b1, 1'b0};
        vecs[1]  = '{8'h03, 8'h0A, 8'hF9, 1'b0, 1'b0};
        vecs[2]  = '{8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'hFB, 8'h02, 8'hF9, 1'b1, 1'b0};
        vecs[4]  = '{8'h05, 8'hFE, 8'h07, 1'b0, 1'b0};
        vecs[5]  = '{8'hFB, 8'hFE, 8'hFD, 1'b0, 1'b0};
        vecs[6]  = '{8'hFE, 8'hFB, 8'h03, 1'b1, 1'b0};
        vecs[7]  = '{8'h7F, 8'h01, 8'h7E, 1'b1, 1'b0};
        vecs[8]  = '{8'h7F, 8'h80, 8'hFF, 1'b0, 1'b1};
        vecs[9]  = '{8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[10] = '{8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};

        // Reset held for two edges with live operands, then release.
        drive(1000, 1'b1, 8'h0A, 8'h03, 8'h00, 1'b0, 1'b0);
        drive(1001, 1'b1, 8'h0A, 8'h03, 8'h00, 1'b0, 1'b0);
        drive(1002, 1'b0, 8'h0A, 8'h03, 8'h07, 1'b1, 1'b0);

        // Directed vectors back-to-back, no bubbles.
        for (int i = 0; i < 11; i++)
            drive(i, 1'b0, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov);

        // Reset mid-stream discards the operands present at that edge.
        drive(2000, 1'b1, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0);
        drive(2001, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // Exhaustive sweep against the arithmetic reference.
        for (int i = 0; i < 65536; i++) begin
            ea = i[15:8];
            eb = i[7:0];
            ed = ea - eb;
            drive(10000 + i, 1'b0, ea, eb, ed, (ea >= eb), (ea[7] ^ eb[7]) & (ea[7] ^ ed[7]));
        end

        @(negedge clk);
        stim_valid = 1'b0;

        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
